// File: rtl/dm_stage.sv
// Data memory for the MEM stage: byte/half/word stores with lane merge, combinational
// extended loads, sticky first-fault capture. Store commits in 1 edge; loads same cycle; no backpressure.
module dm_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addM,
  input  logic [31:0] wdataM,
  input  logic [31:0] PCM,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  mem_op,
  output logic [31:0] rdataM,
  output logic        err,
  output logic [31:0] err_pc
);

  localparam logic [2:0]  OP_W   = 3'b000;
  localparam logic [2:0]  OP_HU  = 3'b001;
  localparam logic [2:0]  OP_H   = 3'b010;
  localparam logic [2:0]  OP_BU  = 3'b011;
  localparam logic [2:0]  OP_B   = 3'b100;
  localparam logic [32:0] LIMIT  = 33'(DEPTH * 4);

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_word, is_half, is_byte;
  logic          in_range, aligned, legal, ok, fault, store_en;
  logic [31:0]   raw, wrep, merged;
  logic [3:0]    be;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;

  assign idx      = addM[AW+1:2];
  assign lane     = addM[1:0];
  assign is_word  = (mem_op == OP_W);
  assign is_half  = (mem_op == OP_HU) || (mem_op == OP_H);
  assign is_byte  = (mem_op == OP_BU) || (mem_op == OP_B);
  // Compare in 33 bits so addresses near 2^32 can never wrap into range.
  assign in_range = ({1'b0, addM} < LIMIT);
  assign aligned  = is_word ? (lane == 2'b00) : (is_half ? ~lane[0] : 1'b1);
  assign legal    = (mem_op <= OP_B);
  assign ok       = in_range & aligned & legal;
  assign fault    = (we | re) & ~ok;
  assign store_en = we & ok;

  assign raw = mem[idx];

  always_comb begin
    be   = 4'b0000;
    wrep = {4{wdataM[7:0]}};
    if (is_word) begin
      be   = 4'b1111;
      wrep = wdataM;
    end else if (is_half) begin
      be   = lane[1] ? 4'b1100 : 4'b0011;
      wrep = {2{wdataM[15:0]}};
    end else if (is_byte) begin
      be   = 4'b0001 << lane;
    end
  end

  // Full post-write word: replicated store data on enabled lanes, old bytes elsewhere.
  always_comb begin
    merged = raw;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wrep[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store_en) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err    <= 1'b0;
      err_pc <= '0;
    end else if (fault && !err) begin
      err    <= 1'b1;
      err_pc <= PCM;
    end
  end

  // Load path reads the pre-edge array; no bypass from a same-cycle store.
  always_comb begin
    half_sel = lane[1] ? raw[31:16] : raw[15:0];
    case (lane)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
  end

  always_comb begin
    rdataM = '0;
    if (re && ok) begin
      case (mem_op)
        OP_W:    rdataM = raw;
        OP_HU:   rdataM = {16'h0000, half_sel};
        OP_H:    rdataM = {{16{half_sel[15]}}, half_sel};
        OP_BU:   rdataM = {24'h000000, byte_sel};
        OP_B:    rdataM = {{24{byte_sel[7]}}, byte_sel};
        default: rdataM = '0;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n && store_en)
      $display("@%h: *%h <= %h", PCM, {addM[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: doc/dm_stage.md
Name: dm_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its address, store data and PC outputs.
- Holds the data memory and performs word, half and byte stores with little-endian byte lanes.
- Returns load data, zero- or sign-extended, combinationally to the MEM/WB register.
- Records the first faulting access (misaligned, out of range, or illegal op) in sticky registers.

Parameters:
DEPTH, 1024, number of 32-bit words; byte address range is 0 to DEPTH*4-1.
AW, 10, word index width (log2 DEPTH).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  asynchronous active-low reset.
addM  in  32  byte address from EX/MEM register.
wdataM  in  32  store data from EX/MEM register; low bits are used for sh/sb.
PCM  in  32  PC of the instruction in MEM; used for the trace and fault capture.
we  in  1  store request this cycle.
re  in  1  load request this cycle.
mem_op  in  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101-111 illegal.
rdataM  out  32  extended load data (combinational).
err  out  1  sticky fault flag (registered).
err_pc  out  32  PCM of the first faulting access (registered).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All DEPTH words <= 0; err <= 0; err_pc <= 0.
  - rdataM therefore reads 0 while reset is held.
  - Reset asserted mid-store: the store is lost and memory is all zero.
- Decode (combinational):
  - idx = addM[AW+1:2]; lane = addM[1:0].
  - in_range = (addM < DEPTH*4).
  - aligned: word needs lane==0; half needs lane[0]==0; byte always aligned.
  - legal = mem_op <= 100.
  - ok = in_range & aligned & legal.
  - fault = (we | re) & ~ok.
- Store (rising edge, we=1 and ok):
  - Word: mem[idx] <= wdataM.
  - Half: bytes lane and lane+1 <= wdataM[15:0]; other bytes unchanged.
  - Byte: byte lane <= wdataM[7:0]; other bytes unchanged.
  - mem_op 001/010 are both "half" for stores; 011/100 are both "byte".
  - Each performed store prints $display("@%h: *%h <= %h", PCM, {addM[31:2],2'b00}, merged_word), where merged_word is the full post-write word.
  - we=1 with ok=0: no write, no display.
- Load (combinational):
  - raw = mem[idx].
  - Word: raw.
  - Half: raw[16*lane[1] +: 16], zero-extended (001) or sign-extended (010).
  - Byte: raw[8*lane +: 8], zero-extended (011) or sign-extended (100).
  - rdataM = 0 when re=0 or ok=0.
- Same-cycle read and write:
  - rdataM always reflects array contents before the pending edge; there is no write-to-read bypass.
  - A load in the cycle after a store to the same word sees the new data.
- Fault capture (rising edge):
  - If fault and err==0: err <= 1, err_pc <= PCM.
  - Later faults leave both registers unchanged. err clears only on reset.
- Latency: store commits 1 edge after presentation; load data valid in the same cycle; err valid 1 edge after the faulting cycle.
- Address bits above the range check are not aliased. Any addM >= DEPTH*4 is a fault.

Test Plan:
- Reset then word store: we=1, mem_op=000, addM=0x0000_0010, wdataM=0xDEAD_BEEF, PCM=0x3000 -> after edge, re=1 word load at 0x10 gives rdataM=0xDEADBEEF; trace prints "@00003000: *00000010 <= deadbeef".
- Byte/half merge: word 0x10=0xDEADBEEF; sb addM=0x11, wdataM=0x55 -> word becomes 0xDEAD55EF; sh addM=0x12, wdataM=0x1234 -> word becomes 0x123455EF; lb addM=0x10 (0xEF) gives 0xFFFF_FFEF; lbu addM=0x10 gives 0x0000_00EF; lh addM=0x12 gives 0x0000_1234.
- Sign extension: word 0x20=0x8001_7FFF -> lh @0x22 gives 0xFFFF_8001; lhu @0x22 gives 0x0000_8001; lh @0x20 gives 0x0000_7FFF.
- Faults: sw addM=0x0000_0012 at PCM=0x3010 -> no write, word unchanged, err=1, err_pc=0x3010 after the edge. Next, lw addM=0x0000_1000 (out of range) at PCM=0x3014 -> rdataM=0, err_pc stays 0x3010. mem_op=111 with re=1 -> rdataM=0.
- Same-cycle read/write: word 0x30=0x1111_1111; present we=1 sw 0x2222_2222 and re=1 lw at 0x30 together -> rdataM=0x11111111 before the edge, 0x22222222 after it.
- Async reset mid-operation: after stores and err=1, drop reset_n between clock edges -> immediately err=0, err_pc=0, and every word reads 0; a store presented while reset_n=0 is not written.
